mmu_seq_nxn: RTL
================

// Module: mmu_seq_nxn
// PURPOSE
//  Parametrised successor to the 2x2 feeder. Sequences one NxN matrix multiply on an
//  external NxN output-stationary systolic array. Latches A/B operands on start, emits
//  the skewed edge streams and clears the PEs. Snapshots the accumulators after drain,
//  then streams results to the host over an 8-bit valid/ready port.
//  Output modes: full-width bytes, or 8-bit saturated.
// PARAMETERS
//  N         2   array dimension (rows = cols); legal 2..8
//  DW        8   operand width, bits
//  AW        16  accumulator width, bits; must be a multiple of 8, AW >= 2*DW
//  DRAIN     N   cycles waited after the last feed beat before snapshot (array pipe latency)
// PORTS
//  clk        in   1        clock; all logic on rising edge
//  rst_n      in   1        reset, synchronous, active-low
//  start      in   1        1-cycle request; sampled only in IDLE
//  abort      in   1        synchronous cancel; wins over everything except rst_n
//  sat_mode   in   1        0: AW/8 bytes per element, LSB first; 1: one saturated byte per element
//  sign_mode  in   1        1: accumulators and saturation are two's complement; 0: unsigned
//  a_mat      in   N*N*DW   A row-major; element [i][k] at bits (i*N+k)*DW +: DW
//  b_mat      in   N*N*DW   B row-major; element [k][j] at bits (k*N+j)*DW +: DW
//  acc        in   N*N*AW   array accumulators; C[i][j] at (i*N+j)*AW +: AW
//  clear      out  1        PE accumulator clear
//  a_edge     out  N*DW     left-edge feed; row i at i*DW +: DW
//  b_edge     out  N*DW     top-edge feed; col j at j*DW +: DW
//  busy       out  1        high in every state except IDLE
//  out_valid  out  1        out_data valid
//  out_ready  in   1        host accepts the byte when out_valid & out_ready
//  out_data   out  8        result byte
//  out_last   out  1        high with the final byte of the matrix
//  done       out  1        1-cycle pulse, cycle after final byte accepted
// BEHAVIOUR
//  Reset: state=IDLE; clear=0, a_edge=b_edge=0, busy=0, out_valid=0, out_data=0,
//   out_last=0, done=0; all counters 0.
//  FSM: IDLE -> CLR -> FEED -> DRAIN -> OUT -> IDLE.
//  IDLE: start=1 latches a_mat, b_mat, sat_mode, sign_mode; next state CLR.
//   Later changes to these inputs are ignored until the next accepted start.
//   start outside IDLE is ignored, with no queueing.
//  CLR: one cycle; clear=1, edges 0.
//  FEED: 2N-1 cycles, beat k=0..2N-2.
//   a_edge row i = A[i][k-i] when 0<=k-i<N, else 0.
//   b_edge col j = B[k-j][j] when 0<=k-j<N, else 0.
//  DRAIN: DRAIN cycles with edges=0. On the last DRAIN cycle, acc is copied to the
//   snapshot register.
//  OUT: elements stream row-major C[0][0]..C[N-1][N-1].
//   sat_mode=0: AW/8 bytes per element, LSB first.
//   sat_mode=1, sign=1: clamp to [-128,127]. sign=0: clamp to [0,255].
//   out_valid rises the first OUT cycle. A new byte is presented each accepted cycle,
//   with no bubbles.
//   Backpressure: out_data/out_last held stable while valid & !ready.
//   Byte count = N*N*(sat_mode ? 1 : AW/8). out_last is set on the last byte.
//   After that byte is accepted: out_valid=0 and done=1 next cycle, state IDLE.
//   A start in the done cycle is accepted.
//  Latency, start to first out_valid: 1+1+(2N-1)+DRAIN cycles (N=2, DRAIN=2: 7).
//  abort in any non-IDLE state: next cycle IDLE, one clear=1 pulse, out_valid=0,
//   edges=0, no done. abort in IDLE: no effect.
//  start and abort in the same IDLE cycle: start ignored.
//  rst_n low mid-operation: reset values next edge, no done, snapshot discarded.
// TESTING
//  T1 N=2,sat=0: A=[[1,2],[3,4]] B=[[5,6],[7,8]] -> 13 00 16 00 2B 00 32 00, last on byte 8, done once
//  T2 N=2,sat=1,sign=0: A=B=all 16 -> C=512 each -> FF FF FF FF; sign=1,A=-16,B=16 -> 80 x4
//  T3 backpressure: out_ready toggled 1010.., then held 0 for 5 cycles -> byte stream identical to T1, data stable while stalled
//  T4 start pulsed during FEED and OUT -> ignored; only one done; busy never drops early
//  T5 abort at FEED beat 1, then rst_n low mid-OUT -> IDLE, out_valid=0, no done; next start gives correct T1 result
//  T6 N=4,DW=8,AW=24 random signed A,B vs reference model; check skew beat k=3 edge values and 48 bytes out
//  Bench: behavioural NxN output-stationary array model driving acc.

Source files
------------

// File: rtl/mmu_seq_nxn.sv
// mmu_seq_nxn
//   Runs one NxN matrix multiply on an external NxN output-stationary systolic
//   array. On start it latches A, B and the output modes, clears the PEs for one
//   cycle, and drives the skewed left/top edge streams for 2N-1 beats. It then
//   waits DRAIN cycles for the array pipeline to settle and snapshots the
//   accumulators. Finally it streams the results row-major over an 8-bit
//   valid/ready port, either as AW/8 bytes per element (LSB first) or as one
//   saturated byte per element.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start, abort          request (sampled in IDLE) / cancel (any busy state)
//   sat_mode, sign_mode   output format and signedness, latched on start
//   a_mat, b_mat          row-major operands, element [r][c] at (r*N+c)*DW
//   acc                   array accumulators, C[i][j] at (i*N+j)*AW
//   clear                 PE accumulator clear
//   a_edge, b_edge        left-edge row feeds / top-edge column feeds
//   busy                  high in every state except IDLE
//   out_valid/out_ready   result byte handshake; out_data, out_last
//   done                  one-cycle pulse after the final byte is accepted
module mmu_seq_nxn #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int DRAIN = N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              sat_mode,
    input  logic              sign_mode,
    input  logic [N*N*DW-1:0] a_mat,
    input  logic [N*N*DW-1:0] b_mat,
    input  logic [N*N*AW-1:0] acc,
    output logic              clear,
    output logic [N*DW-1:0]   a_edge,
    output logic [N*DW-1:0]   b_edge,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              done
);
    localparam int NB   = AW / 8;
    localparam int NE   = N * N;
    localparam int CMAX = (2 * N > DRAIN) ? 2 * N : DRAIN;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(N);
    localparam int EW   = $clog2(NE);
    localparam int BW   = $clog2(NB + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]                   state;
    logic [N-1:0][N-1:0][DW-1:0]  a_q, b_q;   // [row][col] matches row-major packing
    logic                         sat_q, sign_q;
    logic [CW-1:0]                beat;       // FEED beat, then DRAIN cycle count
    logic [NE-1:0][AW-1:0]        snap;
    logic [EW-1:0]                elem;
    logic [BW-1:0]                byte_idx;
    logic                         clr_pulse;  // clear issued the cycle after an abort
    logic                         done_q;

    logic          elem_end, last_byte;
    logic [AW-1:0] cur;
    logic [7:0]    byte_raw, byte_sat;

    assign elem_end  = sat_q || (byte_idx == BW'(NB - 1));
    assign last_byte = (elem == EW'(NE - 1)) && elem_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sat_q     <= 1'b0;
            sign_q    <= 1'b0;
            beat      <= '0;
            snap      <= '0;
            elem      <= '0;
            byte_idx  <= '0;
            clr_pulse <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            state     <= S_IDLE;
            beat      <= '0;
            elem      <= '0;
            byte_idx  <= '0;
            clr_pulse <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            clr_pulse <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort in the same cycle suppresses the start
                    if (start && !abort) begin
                        a_q    <= a_mat;
                        b_q    <= b_mat;
                        sat_q  <= sat_mode;
                        sign_q <= sign_mode;
                        state  <= S_CLR;
                    end
                end
                S_CLR: begin
                    beat  <= '0;
                    state <= S_FEED;
                end
                S_FEED: begin
                    if (beat == CW'(2 * N - 2)) begin
                        beat  <= '0;
                        state <= S_DRAIN;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (beat == CW'(DRAIN - 1)) begin
                        snap     <= acc;
                        beat     <= '0;
                        elem     <= '0;
                        byte_idx <= '0;
                        state    <= S_OUT;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (last_byte) begin
                            elem     <= '0;
                            byte_idx <= '0;
                            done_q   <= 1'b1;
                            state    <= S_IDLE;
                        end else if (elem_end) begin
                            byte_idx <= '0;
                            elem     <= elem + 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign clear     = (state == S_CLR) || clr_pulse;
    assign out_valid = (state == S_OUT);
    assign done      = done_q;

    // Output byte is a pure function of the snapshot and the indices, which only
    // move on an accepted byte, so it holds steady under backpressure.
    always_comb begin
        cur      = snap[elem];
        byte_raw = 8'(cur >> {byte_idx, 3'b000});
        if (sign_q) begin
            // fits in int8 iff bits [AW-1:7] are all copies of the sign
            if ((&cur[AW-1:7]) || !(|cur[AW-1:7])) byte_sat = cur[7:0];
            else byte_sat = cur[AW-1] ? 8'h80 : 8'h7F;
        end else begin
            byte_sat = (|cur[AW-1:8]) ? 8'hFF : cur[7:0];
        end
        out_data = out_valid ? (sat_q ? byte_sat : byte_raw) : 8'h00;
        out_last = out_valid && last_byte;
    end

    // Row g / column g carries operand index k-g on beat k; outside the
    // diagonal window the lane is zero.
    for (genvar g = 0; g < N; g++) begin : g_edge
        logic          in_win;
        logic [IW-1:0] idx;
        assign in_win = (state == S_FEED) && (beat >= CW'(g)) && (beat < CW'(g + N));
        assign idx    = IW'(beat - CW'(g));
        assign a_edge[g*DW +: DW] = in_win ? a_q[g][idx] : '0;
        assign b_edge[g*DW +: DW] = in_win ? b_q[idx][g] : '0;
    end
endmodule
